// File: rtl/bp_pkg.sv
// Shared types and constants for the 2-bit bimodal branch predictor.
// Counter encodings and the in-flight slot bundle live here.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Wide enough for any practical table; tops cast down to IDX_W.
    localparam int BP_IDX_MAX = 16;

    typedef struct packed {
        logic                  valid;
        logic                  pred;
        logic [31:0]           alt_pc;
        logic [BP_IDX_MAX-1:0] idx;
    } bp_slot_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter, one per predictor table entry.
// Resets to weak-not-taken.
module sat_counter2
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WNT;
        end else if (en) begin
            if (inc && state != ST) begin
                state <= state + 2'd1;
            end else if (dec && state != SNT) begin
                state <= state - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor: IF lookup, ID/EX tracking slots, EX-side
// misprediction detection and counter training.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        IF_branch_i,
    input  logic [31:0] IF_pc_i,
    input  logic [31:0] IF_pc_imm_i,
    input  logic [31:0] IF_pc_plus_i,
    input  logic        EX_taken_i,
    output logic        branch_o,
    output logic        miss_o,
    output logic [31:0] PC_branch_o
);

    logic [1:0]       cnt [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    bp_slot_t         if_slot;
    bp_slot_t         id_q;
    bp_slot_t         ex_q;
    logic             upd;
    logic             kill;
    logic             unused_pc;

    assign if_idx    = IF_pc_i[IDX_W+1:2];
    assign unused_pc = ^{IF_pc_i[31:IDX_W+2], IF_pc_i[1:0]};

    assign branch_o = IF_branch_i & cnt[if_idx][1];

    // alt_pc is where to go if this prediction turns out wrong.
    always_comb begin
        if_slot        = '0;
        if_slot.valid  = IF_branch_i;
        if_slot.pred   = branch_o;
        if_slot.alt_pc = branch_o ? IF_pc_plus_i : IF_pc_imm_i;
        if_slot.idx    = BP_IDX_MAX'(if_idx);
    end

    assign miss_o      = ex_q.valid & (ex_q.pred != EX_taken_i);
    assign PC_branch_o = ex_q.valid ? ex_q.alt_pc : 32'd0;
    assign upd         = !stall_i && ex_q.valid;
    assign kill        = miss_o | flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (!stall_i) begin
            id_q <= if_slot;
            ex_q <= id_q;
            if (kill) begin
                id_q.valid <= 1'b0;
                ex_q.valid <= 1'b0;
            end
        end
    end

    // Training is independent of kill, so a flushed miss still learns.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        sat_counter2 u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (upd && ex_q.idx == BP_IDX_MAX'(i)),
            .inc   (EX_taken_i),
            .dec   (!EX_taken_i),
            .state (cnt[i])
        );
    end

endmodule
